// File: rtl/boot_seq_ctrl.sv
// boot_seq_ctrl: streams data then instruction words into the core BRAMs,
// releases the rv32i core for a cycle budget (or until halt), then holds it.
// Ports: clk, rst (async, active-low); start + cfg_* (latched at start);
//        halt; s_valid/s_ready/s_data load stream; d_w_*/i_w_* BRAM writes;
//        d_bram_init_done (write-port mux select), cpu_rst, pc_stall,
//        i_r_enb, rd_enbl core controls; busy, done, run_count status.
module boot_seq_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] cfg_d_words,
    input  logic [ADDR_WIDTH-2:0] cfg_i_words,
    input  logic [CNT_WIDTH-1:0]  cfg_run_cycles,
    input  logic                  halt,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic                  d_bram_init_done,
    output logic                  cpu_rst,
    output logic                  pc_stall,
    output logic                  i_r_enb,
    output logic                  rd_enbl,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  run_count
);

    localparam int IW = ADDR_WIDTH - 1;
    // One BRAM holds 2^(ADDR_WIDTH-2) words; larger counts are clamped.
    localparam logic [IW-1:0] MAX_WORDS = IW'(1) << (ADDR_WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_D,
        S_LOAD_I,
        S_SETTLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         d_cnt_q, d_cnt_d;
    logic [IW-1:0]         i_cnt_q, i_cnt_d;
    logic [CNT_WIDTH-1:0]  run_cfg_q, run_cfg_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  run_count_q, run_count_d;
    logic [ADDR_WIDTH-1:0] d_w_addr_q, d_w_addr_d;
    logic [DATA_WIDTH-1:0] d_w_dat_q, d_w_dat_d;
    logic                  d_w_enb_q, d_w_enb_d;
    logic [ADDR_WIDTH-1:0] i_w_addr_q, i_w_addr_d;
    logic [DATA_WIDTH-1:0] i_w_dat_q, i_w_dat_d;
    logic                  i_w_enb_q, i_w_enb_d;
    logic                  init_done_q, init_done_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  rd_enbl_q, rd_enbl_d;
    logic [ADDR_WIDTH-1:0] word_addr;

    function automatic logic [IW-1:0] clamp(input logic [IW-1:0] n);
        return (n > MAX_WORDS) ? MAX_WORDS : n;
    endfunction

    assign word_addr = ADDR_WIDTH'({idx_q, 2'b00});

    always_comb begin
        state_d     = state_q;
        d_cnt_d     = d_cnt_q;
        i_cnt_d     = i_cnt_q;
        run_cfg_d   = run_cfg_q;
        idx_d       = idx_q;
        run_count_d = run_count_q;
        d_w_addr_d  = d_w_addr_q;
        d_w_dat_d   = d_w_dat_q;
        d_w_enb_d   = 1'b0;
        i_w_addr_d  = i_w_addr_q;
        i_w_dat_d   = i_w_dat_q;
        i_w_enb_d   = 1'b0;
        init_done_d = init_done_q;
        cpu_rst_d   = cpu_rst_q;
        rd_enbl_d   = rd_enbl_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    d_cnt_d     = clamp(cfg_d_words);
                    i_cnt_d     = clamp(cfg_i_words);
                    run_cfg_d   = cfg_run_cycles;
                    idx_d       = '0;
                    run_count_d = '0;
                    init_done_d = 1'b0;
                    cpu_rst_d   = 1'b1;
                    rd_enbl_d   = 1'b0;
                    if (cfg_d_words != '0)
                        state_d = S_LOAD_D;
                    else if (cfg_i_words != '0)
                        state_d = S_LOAD_I;
                    else
                        state_d = S_SETTLE;
                end
            end
            S_LOAD_D: begin
                if (s_valid) begin
                    d_w_enb_d  = 1'b1;
                    d_w_addr_d = word_addr;
                    d_w_dat_d  = s_data;
                    if (idx_q == d_cnt_q - IW'(1)) begin
                        idx_d   = '0;
                        state_d = (i_cnt_q != '0) ? S_LOAD_I : S_SETTLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_LOAD_I: begin
                if (s_valid) begin
                    i_w_enb_d  = 1'b1;
                    i_w_addr_d = word_addr;
                    i_w_dat_d  = s_data;
                    if (idx_q == i_cnt_q - IW'(1)) begin
                        idx_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_SETTLE: begin
                // The last loader write lands during this cycle, so the
                // write-port mux only flips to the core on RUN entry.
                init_done_d = 1'b1;
                cpu_rst_d   = 1'b0;
                rd_enbl_d   = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (run_count_q != '1)
                    run_count_d = run_count_q + CNT_WIDTH'(1);
                if (halt || (run_cfg_q != '0 &&
                             run_count_q == run_cfg_q - CNT_WIDTH'(1)))
                    state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            d_cnt_q     <= '0;
            i_cnt_q     <= '0;
            run_cfg_q   <= '0;
            idx_q       <= '0;
            run_count_q <= '0;
            d_w_addr_q  <= '0;
            d_w_dat_q   <= '0;
            d_w_enb_q   <= 1'b0;
            i_w_addr_q  <= '0;
            i_w_dat_q   <= '0;
            i_w_enb_q   <= 1'b0;
            init_done_q <= 1'b0;
            cpu_rst_q   <= 1'b1;
            rd_enbl_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_cnt_q     <= d_cnt_d;
            i_cnt_q     <= i_cnt_d;
            run_cfg_q   <= run_cfg_d;
            idx_q       <= idx_d;
            run_count_q <= run_count_d;
            d_w_addr_q  <= d_w_addr_d;
            d_w_dat_q   <= d_w_dat_d;
            d_w_enb_q   <= d_w_enb_d;
            i_w_addr_q  <= i_w_addr_d;
            i_w_dat_q   <= i_w_dat_d;
            i_w_enb_q   <= i_w_enb_d;
            init_done_q <= init_done_d;
            cpu_rst_q   <= cpu_rst_d;
            rd_enbl_q   <= rd_enbl_d;
        end
    end

    assign s_ready          = (state_q == S_LOAD_D) || (state_q == S_LOAD_I);
    assign busy             = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done             = (state_q == S_HALT);
    assign pc_stall         = (state_q != S_RUN);
    assign i_r_enb          = (state_q == S_RUN);
    assign rd_enbl          = rd_enbl_q;
    assign cpu_rst          = cpu_rst_q;
    assign d_bram_init_done = init_done_q;
    assign run_count        = run_count_q;
    assign d_w_addr         = d_w_addr_q;
    assign d_w_dat          = d_w_dat_q;
    assign d_w_enb          = d_w_enb_q;
    assign i_w_addr         = i_w_addr_q;
    assign i_w_dat          = i_w_dat_q;
    assign i_w_enb          = i_w_enb_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Bench for boot_seq_ctrl: random word streams and configs checked against
// a word-list memory model, run-length arithmetic and reset expectations.
module tb_boot_seq_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-2:0] cfg_d_words = '0;
    logic [AW-2:0] cfg_i_words = '0;
    logic [CW-1:0] cfg_run_cycles = '0;
    logic          halt = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic [AW-1:0] d_w_addr, i_w_addr;
    logic [DW-1:0] d_w_dat, i_w_dat;
    logic          d_w_enb, i_w_enb;
    logic          d_bram_init_done, cpu_rst, pc_stall;
    logic          i_r_enb, rd_enbl, busy, done;
    logic [CW-1:0] run_count;

    boot_seq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_d_words(cfg_d_words), .cfg_i_words(cfg_i_words),
        .cfg_run_cycles(cfg_run_cycles), .halt(halt),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_bram_init_done(d_bram_init_done), .cpu_rst(cpu_rst),
        .pc_stall(pc_stall), .i_r_enb(i_r_enb), .rd_enbl(rd_enbl),
        .busy(busy), .done(done), .run_count(run_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Monitor: behavioural BRAMs plus running event counters.
    logic [DW-1:0] dmem [256];
    logic [DW-1:0] imem [256];
    int dwr = 0, iwr = 0, bad_wr = 0, stall_low = 0, pre_run = 0;
    logic [AW-1:0] last_i_addr = '0;
    logic prev_acc = 1'b0;

    always @(negedge clk) begin
        if (d_w_enb) begin
            dmem[d_w_addr[AW-1:2]] = d_w_dat;
            dwr++;
            if (!prev_acc) bad_wr++;
        end
        if (i_w_enb) begin
            imem[i_w_addr[AW-1:2]] = i_w_dat;
            last_i_addr = i_w_addr;
            iwr++;
            if (!prev_acc) bad_wr++;
        end
        if (!pc_stall) stall_low++;
        if (busy && pc_stall) pre_run++;
        prev_acc = s_valid && s_ready;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
        check({tag, "_pc_stall"}, 64'(pc_stall), 64'd1);
        check({tag, "_i_r_enb"}, 64'(i_r_enb), 64'd0);
        check({tag, "_rd_enbl"}, 64'(rd_enbl), 64'd0);
        check({tag, "_init_done"}, 64'(d_bram_init_done), 64'd0);
        check({tag, "_enbs"}, 64'({d_w_enb, i_w_enb}), 64'd0);
        check({tag, "_addrs"}, 64'({d_w_addr, i_w_addr}), 64'd0);
        check({tag, "_dats"}, {d_w_dat, i_w_dat}, 64'd0);
        check({tag, "_run_count"}, 64'(run_count), 64'd0);
    endtask

    task automatic do_start(input int d, input int i, input int n);
        cfg_d_words    = (AW-1)'(d);
        cfg_i_words    = (AW-1)'(i);
        cfg_run_cycles = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds words in order; a beat counts when valid && ready before an edge.
    task automatic stream(input string tag, input logic [DW-1:0] words[$],
                          input bit thr, input int budget);
        logic [DW-1:0] q[$];
        bit ph = 1'b0;
        bit acc;
        int cyc = 0;
        q = words;
        while (q.size() > 0 && cyc < budget) begin
            s_valid = thr ? ph : 1'b1;
            ph = ~ph;
            s_data = q[0];
            acc = s_valid && s_ready;
            tick();
            if (acc) void'(q.pop_front());
            cyc++;
        end
        s_valid = 1'b0;
        check({tag, "_stream_drained"}, 64'(q.size()), 64'd0);
    endtask

    task automatic scenario(input string tag, input int d, input int i,
                            input int n, input bit thr, input int halt_at);
        logic [DW-1:0] ed[$], ei[$], all[$];
        logic [DW-1:0] w;
        int nd, ni, exp_run, cyc;
        int dw0, iw0, bw0, sl0, pr0;
        nd = (d > 256) ? 256 : d;
        ni = (i > 256) ? 256 : i;
        for (int k = 0; k < nd; k++) begin
            w = $urandom;
            ed.push_back(w);
            all.push_back(w);
        end
        for (int k = 0; k < ni; k++) begin
            w = $urandom;
            ei.push_back(w);
            all.push_back(w);
        end
        dw0 = dwr; iw0 = iwr; bw0 = bad_wr;
        sl0 = stall_low; pr0 = pre_run;
        do_start(d, i, n);
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        check({tag, "_ready_after_start"}, 64'(s_ready),
              64'((nd + ni) > 0));
        check({tag, "_cpu_rst_load"}, 64'(cpu_rst), 64'd1);
        check({tag, "_init_done_load"}, 64'(d_bram_init_done), 64'd0);
        stream(tag, all, thr, 4 * (nd + ni) + 10);
        if (halt_at > 0) begin
            cyc = 0;
            while (pc_stall && cyc < 10) begin
                tick();
                cyc++;
            end
            check({tag, "_run_entry"}, 64'(pc_stall), 64'd0);
            check({tag, "_run_i_r_enb"}, 64'(i_r_enb), 64'd1);
            check({tag, "_run_rd_enbl"}, 64'(rd_enbl), 64'd1);
            check({tag, "_run_cpu_rst"}, 64'(cpu_rst), 64'd0);
            check({tag, "_run_init_done"}, 64'(d_bram_init_done), 64'd1);
            repeat (halt_at - 1) tick();
            halt = 1'b1;
            tick();
            halt = 1'b0;
            exp_run = halt_at;
        end else begin
            exp_run = n;
        end
        cyc = 0;
        while (!done && cyc < exp_run + 20) begin
            tick();
            cyc++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_halt"}, 64'(busy), 64'd0);
        check({tag, "_run_count"}, 64'(run_count), 64'(exp_run));
        check({tag, "_stall_low"}, 64'(stall_low - sl0), 64'(exp_run));
        check({tag, "_pc_stall_halt"}, 64'(pc_stall), 64'd1);
        check({tag, "_i_r_enb_halt"}, 64'(i_r_enb), 64'd0);
        check({tag, "_init_done_halt"}, 64'(d_bram_init_done), 64'd1);
        check({tag, "_cpu_rst_halt"}, 64'(cpu_rst), 64'd0);
        check({tag, "_d_writes"}, 64'(dwr - dw0), 64'(nd));
        check({tag, "_i_writes"}, 64'(iwr - iw0), 64'(ni));
        check({tag, "_stray_writes"}, 64'(bad_wr - bw0), 64'd0);
        if (!thr)
            check({tag, "_load_cycles"}, 64'(pre_run - pr0),
                  64'(nd + ni + 1));
        for (int k = 0; k < nd; k++)
            check($sformatf("%s_dmem%0d", tag, k), 64'(dmem[k]), 64'(ed[k]));
        for (int k = 0; k < ni; k++)
            check($sformatf("%s_imem%0d", tag, k), 64'(imem[k]), 64'(ei[k]));
    endtask

    initial begin
        logic [DW-1:0] part[$];
        int rd, ri, rn;
        bit rt;

        repeat (3) tick();
        check_reset("por");
        rst = 1'b1;
        tick();
        check_reset("idle");

        scenario("dir", 3, 20, 20, 1'b0, 0);
        scenario("thr", 3, 20, 20, 1'b1, 0);
        scenario("zero", 0, 0, 5, 1'b0, 0);
        scenario("halt", 2, 2, 0, 1'b0, 7);

        do_start(2, 10, 0);
        check("restart_cpu_rst", 64'(cpu_rst), 64'd1);
        check("restart_init_done", 64'(d_bram_init_done), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_done", 64'(done), 64'd0);
        check("restart_rd_enbl", 64'(rd_enbl), 64'd0);
        check("restart_run_count", 64'(run_count), 64'd0);

        for (int k = 0; k < 7; k++) part.push_back($urandom);
        stream("mid", part, 1'b0, 20);
        check("mid_in_load_i", 64'(i_w_enb), 64'd1);
        rst = 1'b0;
        #1;
        check_reset("mid_rst");
        start = 1'b1;
        cfg_i_words = 9'd4;
        tick();
        start = 1'b0;
        check("start_in_rst", 64'(busy), 64'd0);
        rst = 1'b1;
        tick();
        check("start_after_rst", 64'(busy), 64'd0);
        check_reset("rst_released");

        scenario("bnd", 0, 256, 3, 1'b0, 0);
        check("bnd_last_addr", 64'(last_i_addr), 64'h3FC);

        for (int r = 0; r < 4; r++) begin
            rd = $urandom_range(0, 300);
            ri = $urandom_range(0, 40);
            rn = $urandom_range(1, 40);
            rt = 1'($urandom_range(0, 1));
            scenario($sformatf("rnd%0d", r), rd, ri, rn, rt, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
